// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Used by the holding buffers and the writeback arbiter.
package regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  // Relative age of the two buffered entries; AGE_SAME also covers "only one is full".
  typedef enum logic [1:0] {
    AGE_SAME      = 2'd0,
    AGE_ALU_OLDER = 2'd1,
    AGE_MEM_OLDER = 2'd2
  } age_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] dest_mask(input logic valid, input logic [ADDR_W-1:0] dest);
    return valid ? (NREG'(1) << dest) : '0;
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer. A load takes priority over a clear so a
// drained entry can be replaced by a new one on the same edge.
module wb_hold_buf
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  wb_entry_t din,
  output logic      full,
  output wb_entry_t entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; full qualifies it, so these flops stay reset-free.
  always_ff @(posedge clk) begin
    if (load) begin
      entry <= din;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and load
// writeback buffers, preserving same-destination order and exporting pending writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write,
  output logic [ADDR_W-1:0] destreg,
  output logic [DATA_W-1:0] wrtData,
  output logic              grant_mem,
  output logic [NREG-1:0]   pending
);

  wb_entry_t alu_q, mem_q;
  logic      alu_full, mem_full;
  logic      alu_load, mem_load;
  logic      alu_clear, mem_clear;
  logic      active, both_full, mem_wins, sel_mem;
  wb_src_e   rr_q;
  age_e      age_q, age_d;
  wb_entry_t sel_entry;

  wb_hold_buf u_alu_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (alu_load),
    .clear (alu_clear),
    .din   ('{dest: alu_dest, data: alu_data}),
    .full  (alu_full),
    .entry (alu_q)
  );

  wb_hold_buf u_mem_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (mem_load),
    .clear (mem_clear),
    .din   ('{dest: mem_dest, data: mem_data}),
    .full  (mem_full),
    .entry (mem_q)
  );

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    both_full = alu_full & mem_full;
    mem_wins  = 1'b0;
    unique case (age_q)
      AGE_ALU_OLDER: mem_wins = 1'b0;
      AGE_MEM_OLDER: mem_wins = 1'b1;
      // Same-cycle loads: the load is the older instruction when destinations collide.
      default:       mem_wins = (alu_q.dest == mem_q.dest) | (rr_q == SRC_MEM);
    endcase

    sel_mem   = mem_full & (~alu_full | mem_wins);
    active    = ~rst & (alu_full | mem_full);
    alu_clear = active & ~sel_mem;
    mem_clear = active & sel_mem;

    alu_ready = ~rst & (~alu_full | alu_clear);
    mem_ready = ~rst & (~mem_full | mem_clear);
    alu_load  = alu_valid & alu_ready;
    mem_load  = mem_valid & mem_ready;

    sel_entry = sel_mem ? mem_q : alu_q;
    write     = active;
    grant_mem = mem_clear;
    destreg   = active ? sel_entry.dest : '0;
    wrtData   = active ? sel_entry.data : '0;
    pending   = rst ? '0 : (dest_mask(alu_full, alu_q.dest) | dest_mask(mem_full, mem_q.dest));
  end

  // The newly loaded entry is younger than whatever the other buffer keeps past this edge.
  always_comb begin
    age_d = age_q;
    if (alu_load && mem_load) begin
      age_d = AGE_SAME;
    end else if (alu_load) begin
      age_d = (mem_full && !mem_clear) ? AGE_MEM_OLDER : AGE_SAME;
    end else if (mem_load) begin
      age_d = (alu_full && !alu_clear) ? AGE_ALU_OLDER : AGE_SAME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= SRC_ALU;
      age_q <= AGE_SAME;
    end else begin
      age_q <= age_d;
      if (active && both_full) begin
        rr_q <= (rr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change and outputs are checked on
// the falling edge; a small register-file model captures writes on the rising edge.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic [ADDR_W-1:0] alu_dest = '0, mem_dest = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic              alu_ready, mem_ready, write, grant_mem;
  logic [ADDR_W-1:0] destreg;
  logic [DATA_W-1:0] wrtData;
  logic [NREG-1:0]   pending;

  logic [DATA_W-1:0] rf [NREG] = '{default: 8'h00};
  int errors = 0;
  int checks = 0;
  logic [12:0] wb;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .write     (write),
    .destreg   (destreg),
    .wrtData   (wrtData),
    .grant_mem (grant_mem),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) rf[destreg] <= wrtData;
  end

  // {write, grant_mem, destreg, wrtData}
  assign wb = {write, grant_mem, destreg, wrtData};

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 8'h77;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if ({alu_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {alu_ready, mem_ready}); end
      checks++; if (wb !== 13'h0) begin errors++; $display("FAIL reset_wb: got %h want 0", wb); end
      checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
    end
    rst = 1'b0; alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (wb !== 13'h0) begin errors++; $display("FAIL idle_wb: got %h want 0", wb); end
      checks++; if ({alu_ready, mem_ready, pending} !== {2'b11, 8'h00}) begin errors++; $display("FAIL idle_state: got %h want 300", {alu_ready, mem_ready, pending}); end
    end
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 8'h5A;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++; if (wb !== {1'b1, 1'b0, 3'd3, 8'h5A}) begin errors++; $display("FAIL single_wb: got %h want %h", wb, {1'b1, 1'b0, 3'd3, 8'h5A}); end
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL single_pending: got %h want 08", pending); end
    @(negedge clk);
    checks++; if (rf[3] !== 8'h5A) begin errors++; $display("FAIL single_rf3: got %h want 5a", rf[3]); end
    checks++; if ({write, pending} !== 9'h0) begin errors++; $display("FAIL single_drained: got %h want 0", {write, pending}); end
  endtask

  task automatic test_contention(input logic mem_first, input logic [7:0] ad, input logic [7:0] md);
    alu_valid = 1'b1; alu_dest = 3'd1; alu_data = ad;
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = md;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    if (mem_first) begin
      checks++; if (wb !== {1'b1, 1'b1, 3'd2, md}) begin errors++; $display("FAIL cont_first_wb: got %h want %h", wb, {1'b1, 1'b1, 3'd2, md}); end
      checks++; if ({alu_ready, mem_ready} !== 2'b01) begin errors++; $display("FAIL cont_first_ready: got %b want 01", {alu_ready, mem_ready}); end
    end else begin
      checks++; if (wb !== {1'b1, 1'b0, 3'd1, ad}) begin errors++; $display("FAIL cont_first_wb: got %h want %h", wb, {1'b1, 1'b0, 3'd1, ad}); end
      checks++; if ({alu_ready, mem_ready} !== 2'b10) begin errors++; $display("FAIL cont_first_ready: got %b want 10", {alu_ready, mem_ready}); end
    end
    checks++; if (pending !== 8'h06) begin errors++; $display("FAIL cont_pending: got %h want 06", pending); end
    @(negedge clk);
    if (mem_first) begin
      checks++; if (wb !== {1'b1, 1'b0, 3'd1, ad}) begin errors++; $display("FAIL cont_second_wb: got %h want %h", wb, {1'b1, 1'b0, 3'd1, ad}); end
    end else begin
      checks++; if (wb !== {1'b1, 1'b1, 3'd2, md}) begin errors++; $display("FAIL cont_second_wb: got %h want %h", wb, {1'b1, 1'b1, 3'd2, md}); end
    end
    checks++; if ({alu_ready, mem_ready} !== 2'b11) begin errors++; $display("FAIL cont_second_ready: got %b want 11", {alu_ready, mem_ready}); end
    @(negedge clk);
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b want 0", write); end
    checks++; if ({rf[1], rf[2]} !== {ad, md}) begin errors++; $display("FAIL cont_rf: got %h want %h", {rf[1], rf[2]}, {ad, md}); end
  endtask

  task automatic test_waw();
    alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 8'hAA;
    mem_valid = 1'b1; mem_dest = 3'd4; mem_data = 8'hBB;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (wb !== {1'b1, 1'b1, 3'd4, 8'hBB}) begin errors++; $display("FAIL waw_first: got %h want %h", wb, {1'b1, 1'b1, 3'd4, 8'hBB}); end
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL waw_pending: got %h want 10", pending); end
    @(negedge clk);
    checks++; if (wb !== {1'b1, 1'b0, 3'd4, 8'hAA}) begin errors++; $display("FAIL waw_second: got %h want %h", wb, {1'b1, 1'b0, 3'd4, 8'hAA}); end
    @(negedge clk);
    checks++; if (rf[4] !== 8'hAA) begin errors++; $display("FAIL waw_rf4: got %h want aa", rf[4]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++; if (wb !== {1'b1, 1'b0, 3'(i), 8'(8'hC0 + i)}) begin errors++; $display("FAIL stream_wb%0d: got %h want %h", i, wb, {1'b1, 1'b0, 3'(i), 8'(8'hC0 + i)}); end
      end
      if (i < 4) begin
        alu_valid = 1'b1; alu_dest = 3'(i + 1); alu_data = 8'(8'hC1 + i);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, alu_ready); end
      end else begin
        alu_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL stream_end: got %b want 0", write); end
    checks++; if ({rf[1], rf[2], rf[3], rf[4]} !== 32'hC1C2C3C4) begin errors++; $display("FAIL stream_rf: got %h want c1c2c3c4", {rf[1], rf[2], rf[3], rf[4]}); end
  endtask

  task automatic test_reset_mid_op();
    alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 8'h55;
    mem_valid = 1'b1; mem_dest = 3'd6; mem_data = 8'h66;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (pending !== 8'h60) begin errors++; $display("FAIL rstmid_full: got %h want 60", pending); end
    rst = 1'b1;
    #1;
    checks++; if ({write, pending} !== 9'h0) begin errors++; $display("FAIL rstmid_gate: got %h want 0", {write, pending}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({alu_ready, mem_ready, pending} !== {2'b11, 8'h00}) begin errors++; $display("FAIL rstmid_after: got %h want 300", {alu_ready, mem_ready, pending}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (write !== 1'b0) begin errors++; $display("FAIL rstmid_nowrite%0d: got %b want 0", i, write); end
    end
    checks++; if ({rf[5], rf[6]} !== 16'h0000) begin errors++; $display("FAIL rstmid_rf: got %h want 0000", {rf[5], rf[6]}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_alu();
    test_contention(1'b0, 8'h11, 8'h22);
    test_contention(1'b1, 8'h33, 8'h44);
    test_waw();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
